// File: rtl/pll_lock_ctrl_pkg.sv
// Shared types and the charge-pump / loop-filter settings table for pll_lock_ctrl.

package pll_lock_ctrl_pkg;

   typedef enum logic [1:0] {
      RST       = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } pll_state_t;

   typedef struct packed {
      logic [5:0] icpsel;
      logic [2:0] lpfres;
      logic [1:0] lpfcap;
   } pll_lpf_t;

   // Ordered so the most likely-good setting is tried first after reset.
   localparam pll_lpf_t PLL_LPF_TABLE [4] = '{
      '{icpsel: 6'd16, lpfres: 3'd2, lpfcap: 2'd0},
      '{icpsel: 6'd24, lpfres: 3'd3, lpfcap: 2'd0},
      '{icpsel: 6'd8,  lpfres: 3'd1, lpfcap: 2'd1},
      '{icpsel: 6'd32, lpfres: 3'd4, lpfcap: 2'd1}
   };

   function automatic pll_lpf_t pll_lpf_lookup(input logic [1:0] idx);
      return PLL_LPF_TABLE[idx];
   endfunction

endpackage

// File: rtl/pll_lock_ctrl_sync2.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.

module pll_lock_ctrl_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL lock supervisor: resets the PLL, retries through loop-filter settings on timeout,
// releases sys_reset once lock is stable. Status counters need PLL_LOCK_CTRL_STATUS_EN.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// RST       | pll_reset held high for RST_CYCLES, new settings applied
// WAIT_LOCK | PLL running, waiting for lock up to LOCK_TIMEOUT cycles
// STABLE    | lock seen, waiting for STABLE_CYCLES consecutive lock cycles
// RUN       | lock stable, sys_reset released

module pll_lock_ctrl
   import pll_lock_ctrl_pkg::*;
#(
   parameter int RST_CYCLES    = 64,
   parameter int LOCK_TIMEOUT  = 500000,
   parameter int STABLE_CYCLES = 50000,
   parameter int NUM_SETTINGS  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [5:0] icpsel,
   output logic [2:0] lpfres,
   output logic [1:0] lpfcap,
   output logic       sys_reset,
   output logic       locked,
   output logic [1:0] setting_idx,
   output logic [7:0] relock_count,
   output logic [7:0] timeout_count
);

   localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
   localparam int CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [1:0]       IDX_LAST    = 2'(NUM_SETTINGS - 1);

   logic lock_s;

   pll_lock_ctrl_sync2 u_sync2 (
      .clk   (clk),
      .reset (reset),
      .d     (pll_lock),
      .q     (lock_s)
   );

   pll_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   pll_lpf_t         lpf_q, lpf_d;
   logic             pll_reset_q, pll_reset_d;
   logic             sys_reset_q, sys_reset_d;
   logic             locked_q, locked_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      lpf_d   = lpf_q;
      unique case (state_q)
         RST: begin
            if (cnt_q == RST_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               idx_d   = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
               state_d = RST;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = RST;
               cnt_d   = '0;
            end
         end
      endcase
      // Settings only move on the edge into RST, so the PLL never sees them change while running.
      if (state_d == RST && state_q != RST) begin
         lpf_d = pll_lpf_lookup(idx_d);
      end
      pll_reset_d = (state_d == RST);
      sys_reset_d = (state_d != RUN);
      locked_d    = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RST;
         cnt_q       <= '0;
         idx_q       <= 2'd0;
         lpf_q       <= pll_lpf_lookup(2'd0);
         pll_reset_q <= 1'b1;
         sys_reset_q <= 1'b1;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         lpf_q       <= lpf_d;
         pll_reset_q <= pll_reset_d;
         sys_reset_q <= sys_reset_d;
         locked_q    <= locked_d;
      end
   end

   assign pll_reset   = pll_reset_q;
   assign sys_reset   = sys_reset_q;
   assign locked      = locked_q;
   assign setting_idx = idx_q;
   assign icpsel      = lpf_q.icpsel;
   assign lpfres      = lpf_q.lpfres;
   assign lpfcap      = lpf_q.lpfcap;

`ifdef PLL_LOCK_CTRL_STATUS_EN
   logic [7:0] relock_count_q, relock_count_d;
   logic [7:0] timeout_count_q, timeout_count_d;

   always_comb begin
      relock_count_d  = relock_count_q;
      timeout_count_d = timeout_count_q;
      if (state_q == RUN && !lock_s && relock_count_q != 8'hFF) begin
         relock_count_d = relock_count_q + 8'd1;
      end
      if (state_q == WAIT_LOCK && !lock_s && cnt_q == TO_LAST && timeout_count_q != 8'hFF) begin
         timeout_count_d = timeout_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         relock_count_q  <= 8'd0;
         timeout_count_q <= 8'd0;
      end else begin
         relock_count_q  <= relock_count_d;
         timeout_count_q <= timeout_count_d;
      end
   end

   assign relock_count  = relock_count_q;
   assign timeout_count = timeout_count_q;
`else
   assign relock_count  = 8'd0;
   assign timeout_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8.

module tb_pll_lock_ctrl;

`ifdef PLL_LOCK_CTRL_STATUS_EN
   localparam bit STATUS_EN = 1'b1;
`else
   localparam bit STATUS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pll_lock = 1'b0;
   logic       pll_reset;
   logic [5:0] icpsel;
   logic [2:0] lpfres;
   logic [1:0] lpfcap;
   logic       sys_reset;
   logic       locked;
   logic [1:0] setting_idx;
   logic [7:0] relock_count;
   logic [7:0] timeout_count;

   pll_lock_ctrl #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (100),
      .STABLE_CYCLES (8),
      .NUM_SETTINGS  (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .pll_lock      (pll_lock),
      .pll_reset     (pll_reset),
      .icpsel        (icpsel),
      .lpfres        (lpfres),
      .lpfcap        (lpfcap),
      .sys_reset     (sys_reset),
      .locked        (locked),
      .setting_idx   (setting_idx),
      .relock_count  (relock_count),
      .timeout_count (timeout_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int exp_icp [4] = '{16, 24, 8, 32};
   int exp_res [4] = '{2, 3, 1, 4};
   int exp_cap [4] = '{0, 0, 1, 1};

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int stat(input int n);
      return STATUS_EN ? n : 0;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold reset for three edges; returns on the negedge after the last reset edge.
   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      pll_lock = 1'b0;
      tick(3);
      reset = 1'b0;
   endtask

   // sel: 0 = pll_reset low, 1 = pll_reset high, 2 = sys_reset low.
   function automatic bit cond_met(input int sel);
      case (sel)
         0:       return pll_reset === 1'b0;
         1:       return pll_reset === 1'b1;
         default: return sys_reset === 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int max, output int n, output bit saw_prst);
      n        = 0;
      saw_prst = 1'b0;
      while (!cond_met(sel) && n < max) begin
         @(negedge clk);
         n++;
         if (pll_reset === 1'b1) saw_prst = 1'b1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  saw;

      // Reset values, clean lock, then lock loss in RUN.
      do_reset();
      check_val("rst_pll_reset", pll_reset, 1);
      check_val("rst_sys_reset", sys_reset, 1);
      check_val("rst_locked", locked, 0);
      check_val("rst_idx", setting_idx, 0);
      check_val("rst_icpsel", icpsel, 16);
      check_val("rst_lpfres", lpfres, 2);
      check_val("rst_lpfcap", lpfcap, 0);
      check_val("rst_timeout_cnt", timeout_count, 0);
      check_val("rst_relock_cnt", relock_count, 0);

      wait_for(0, 50, n, saw);
      check_val("prst_fall_lat", n, 4);

      pll_lock = 1'b1;
      wait_for(2, 50, n, saw);
      check_val("clean_lock_lat", n, 11);
      check_val("clean_no_prst", saw, 0);
      check_val("clean_locked", locked, 1);
      check_val("clean_idx", setting_idx, 0);
      check_val("clean_icpsel", icpsel, 16);

      pll_lock = 1'b0;
      wait_for(1, 50, n, saw);
      check_val("loss_prst_lat", n, 3);
      check_val("loss_sys_reset", sys_reset, 1);
      check_val("loss_locked", locked, 0);
      check_val("loss_relock_cnt", relock_count, stat(1));
      check_val("loss_idx", setting_idx, 0);

      pll_lock = 1'b1;
      wait_for(2, 50, n, saw);
      check_val("relock_lat", n, 13);
      check_val("relock_locked", locked, 1);
      check_val("relock_idx", setting_idx, 0);
      check_val("relock_timeout_cnt", timeout_count, 0);

      // One-cycle dropout during STABLE restarts the stable window.
      do_reset();
      tick(4);
      pll_lock = 1'b1;
      tick(5);
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      wait_for(2, 50, n, saw);
      check_val("glitch_lat", n, 11);
      check_val("glitch_no_prst", saw, 0);
      check_val("glitch_idx", setting_idx, 0);

      // Timeout stepping through the whole table and wrapping.
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         tick(103);
         check_val("to_pre_prst", pll_reset, 0);
         check_val("to_pre_idx", setting_idx, i - 1);
         check_val("to_pre_icpsel", icpsel, exp_icp[i - 1]);
         tick(1);
         check_val("to_prst", pll_reset, 1);
         check_val("to_idx", setting_idx, i % 4);
         check_val("to_icpsel", icpsel, exp_icp[i % 4]);
         check_val("to_lpfres", lpfres, exp_res[i % 4]);
         check_val("to_lpfcap", lpfcap, exp_cap[i % 4]);
         check_val("to_timeout_cnt", timeout_count, stat(i));
         check_val("to_sys_reset", sys_reset, 1);
      end

      // Reset in WAIT_LOCK with setting 2 applied.
      tick(208);
      tick(10);
      check_val("mid_pre_prst", pll_reset, 0);
      check_val("mid_pre_idx", setting_idx, 2);
      check_val("mid_pre_icpsel", icpsel, 8);
      check_val("mid_pre_timeout_cnt", timeout_count, stat(6));
      reset = 1'b1;
      tick(1);
      check_val("mid_idx", setting_idx, 0);
      check_val("mid_icpsel", icpsel, 16);
      check_val("mid_prst", pll_reset, 1);
      check_val("mid_timeout_cnt", timeout_count, 0);
      check_val("mid_relock_cnt", relock_count, 0);
      check_val("mid_sys_reset", sys_reset, 1);
      reset = 1'b0;

      // 256 timeouts: counter must hold at 255 rather than wrap.
      do_reset();
      tick(104 * 256);
      check_val("sat_timeout_cnt", timeout_count, stat(255));
      check_val("sat_idx", setting_idx, 0);
      check_val("sat_prst", pll_reset, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
